// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives PC, IR, regfile, ALU, immediate-format and data-memory controls.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic [2:0]  ext_op,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wd_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  state_o,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [TO_W-1:0]   cnt_reg, cnt_next;
  logic              active_reg;
  logic              illegal_reg, illegal_next;
  logic              bus_err_reg, bus_err_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch, is_jal, is_jalr, legal;
  logic [2:0] ext_dec;
  logic       src_a_dec, src_b_dec;
  logic [1:0] alu_op_dec, wd_sel_dec;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  // Per-opcode immediate format, ALU setup and writeback source.
  always_comb begin
    legal      = 1'b1;
    ext_dec    = 3'b000;
    src_a_dec  = 1'b0;
    src_b_dec  = 1'b0;
    alu_op_dec = 2'b00;
    wd_sel_dec = 2'b00;
    unique case (opcode)
      OP_R:      alu_op_dec = 2'b01;
      OP_IMM: begin
        ext_dec    = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b001 : 3'b000;
        src_b_dec  = 1'b1;
        alu_op_dec = 2'b01;
      end
      OP_LOAD: begin
        src_b_dec  = 1'b1;
        wd_sel_dec = 2'b01;
      end
      OP_STORE: begin
        ext_dec   = 3'b010;
        src_b_dec = 1'b1;
      end
      OP_BRANCH: begin
        ext_dec    = 3'b011;
        alu_op_dec = 2'b10;
      end
      OP_JAL: begin
        ext_dec    = 3'b100;
        src_a_dec  = 1'b1;
        src_b_dec  = 1'b1;
        wd_sel_dec = 2'b10;
      end
      OP_JALR: begin
        src_b_dec  = 1'b1;
        wd_sel_dec = 2'b10;
      end
      OP_LUI: begin
        ext_dec    = 3'b101;
        src_b_dec  = 1'b1;
        alu_op_dec = 2'b11;
      end
      OP_AUIPC: begin
        ext_dec   = 3'b101;
        src_a_dec = 1'b1;
        src_b_dec = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

  // active_reg keeps every output low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= '0;
      active_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      active_reg  <= 1'b1;
      illegal_reg <= illegal_next;
      bus_err_reg <= bus_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    illegal_next = illegal_reg;
    bus_err_next = bus_err_reg;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    npc_sel      = 2'b00;
    ext_op       = 3'b000;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'b00;
    reg_we       = 1'b0;
    wd_sel       = 2'b00;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    if (state_reg != S_FETCH && state_reg != S_TRAP) begin
      ext_op = ext_dec;
    end
    if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
      alu_src_a = src_a_dec;
      alu_src_b = src_b_dec;
      alu_op    = alu_op_dec;
    end
    unique case (state_reg)
      S_FETCH: if (active_reg) begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (cnt_reg == TO_LAST) begin
          state_next   = S_TRAP;
          bus_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXEC;
        end else begin
          state_next   = S_TRAP;
          illegal_next = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we      = br_taken;
          npc_sel    = 2'b01;
          state_next = S_FETCH;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          state_next = is_store ? S_FETCH : S_WB;
        end else if (cnt_reg == TO_LAST) begin
          state_next   = S_TRAP;
          bus_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + TO_W'(1);
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wd_sel     = wd_sel_dec;
        pc_we      = is_jal | is_jalr;
        npc_sel    = is_jalr ? 2'b10 : (is_jal ? 2'b01 : 2'b00);
        state_next = S_FETCH;
      end
      default: state_next = S_TRAP;
    endcase
  end

  assign state_o = state_reg;
  assign illegal = illegal_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; one task per scenario with hand-derived expectations.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
  logic        imem_req, ir_we, pc_we, alu_src_a, alu_src_b, reg_we, dmem_req, dmem_we, illegal, bus_err;
  logic [1:0]  npc_sel, alu_op, wd_sel;
  logic [2:0]  ext_op, state_o;
  logic [21:0] allout;

  int asserts = 0;
  int fails   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
    .ext_op(ext_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .wd_sel(wd_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .state_o(state_o), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign allout = {imem_req, ir_we, pc_we, npc_sel, ext_op, alu_src_a, alu_src_b, alu_op,
                   reg_we, wd_sel, dmem_req, dmem_we, state_o, illegal, bus_err};

  // Inputs change on the falling edge; outputs are examined 1 ns later.
  task automatic next_cyc(input logic ia, input logic da, input logic bt);
    @(negedge clk);
    imem_ack = ia;
    dmem_ack = da;
    br_taken = bt;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    #1;
    asserts++;
    if (allout !== 22'd0) begin fails++; $display("FAIL reset_hold: got %b expected all zero", allout); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    asserts++;
    if (allout !== 22'd0) begin fails++; $display("FAIL reset_release: got %b expected all zero", allout); end
  endtask

  task automatic fetch(input int waits, input logic [31:0] ins);
    for (int w = 0; w < waits; w++) begin
      next_cyc(1'b0, 1'b0, 1'b0);
      asserts++;
      if ({state_o, imem_req, ir_we, pc_we} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
        fails++; $display("FAIL fetch_wait: got %b expected %b", {state_o, imem_req, ir_we, pc_we}, {3'd0, 3'b100});
      end
    end
    instr = ins;
    next_cyc(1'b1, 1'b0, 1'b0);
    asserts++;
    if ({state_o, imem_req, ir_we, pc_we, npc_sel} !== {3'd0, 1'b1, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL fetch_ack: got %b expected %b", {state_o, imem_req, ir_we, pc_we, npc_sel}, {3'd0, 5'b11100});
    end
  endtask

  task automatic test_reset();
    do_reset();
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, imem_req} !== {3'd0, 1'b1}) begin
      fails++; $display("FAIL first_req: got %b expected %b", {state_o, imem_req}, 4'b0001);
    end
  endtask

  task automatic test_addi();
    do_reset();
    fetch(2, 32'h00500093);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, ext_op, ir_we, reg_we} !== {3'd1, 3'b000, 1'b0, 1'b0}) begin
      fails++; $display("FAIL addi_decode: got %b expected %b", {state_o, ext_op, ir_we, reg_we}, 8'b00100000);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, alu_src_a, alu_src_b, alu_op, reg_we, ir_we} !== {3'd2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0}) begin
      fails++; $display("FAIL addi_exec: got %b expected %b", {state_o, alu_src_a, alu_src_b, alu_op, reg_we, ir_we}, 9'b010010100);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, reg_we, wd_sel, pc_we, ir_we} !== {3'd4, 1'b1, 2'b00, 1'b0, 1'b0}) begin
      fails++; $display("FAIL addi_wb: got %b expected %b", {state_o, reg_we, wd_sel, pc_we, ir_we}, 8'b10010000);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, reg_we, imem_req} !== {3'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL addi_refetch: got %b expected %b", {state_o, reg_we, imem_req}, 5'b00001);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    fetch(0, 32'h0000A103);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, ext_op} !== {3'd1, 3'b000}) begin
      fails++; $display("FAIL lw_decode: got %b expected %b", {state_o, ext_op}, 6'b001000);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, alu_op, alu_src_b, dmem_req} !== {3'd2, 2'b00, 1'b1, 1'b0}) begin
      fails++; $display("FAIL lw_exec: got %b expected %b", {state_o, alu_op, alu_src_b, dmem_req}, 7'b0100010);
    end
    for (int i = 0; i < 4; i++) begin
      next_cyc(1'b0, (i == 3), 1'b0);
      asserts++;
      if ({state_o, dmem_req, dmem_we, reg_we} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
        fails++; $display("FAIL lw_mem%0d: got %b expected %b", i, {state_o, dmem_req, dmem_we, reg_we}, 6'b011100);
      end
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, reg_we, wd_sel, dmem_req} !== {3'd4, 1'b1, 2'b01, 1'b0}) begin
      fails++; $display("FAIL lw_wb: got %b expected %b", {state_o, reg_we, wd_sel, dmem_req}, 7'b1001010);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, imem_req} !== {3'd0, 1'b1}) begin
      fails++; $display("FAIL lw_refetch: got %b expected %b", {state_o, imem_req}, 4'b0001);
    end
    fetch(0, 32'h0020A023);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, ext_op} !== {3'd1, 3'b010}) begin
      fails++; $display("FAIL sw_decode: got %b expected %b", {state_o, ext_op}, 6'b001010);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, alu_src_b, reg_we} !== {3'd2, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sw_exec: got %b expected %b", {state_o, alu_src_b, reg_we}, 5'b01010);
    end
    next_cyc(1'b0, 1'b1, 1'b0);
    asserts++;
    if ({state_o, dmem_req, dmem_we, reg_we, ext_op} !== {3'd3, 1'b1, 1'b1, 1'b0, 3'b010}) begin
      fails++; $display("FAIL sw_mem: got %b expected %b", {state_o, dmem_req, dmem_we, reg_we, ext_op}, 9'b011110010);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, reg_we, dmem_req, imem_req} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL sw_done: got %b expected %b", {state_o, reg_we, dmem_req, imem_req}, 6'b000001);
    end
  endtask

  task automatic test_branch();
    do_reset();
    fetch(0, 32'h00208463);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, ext_op} !== {3'd1, 3'b011}) begin
      fails++; $display("FAIL beq_decode: got %b expected %b", {state_o, ext_op}, 6'b001011);
    end
    next_cyc(1'b0, 1'b0, 1'b1);
    asserts++;
    if ({state_o, pc_we, npc_sel, ext_op, alu_op, reg_we} !== {3'd2, 1'b1, 2'b01, 3'b011, 2'b10, 1'b0}) begin
      fails++; $display("FAIL beq_taken: got %b expected %b", {state_o, pc_we, npc_sel, ext_op, alu_op, reg_we}, 12'b010101011100);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, imem_req, pc_we} !== {3'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL beq_refetch: got %b expected %b", {state_o, imem_req, pc_we}, 5'b00010);
    end
    fetch(0, 32'h00208463);
    next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, pc_we, npc_sel} !== {3'd2, 1'b0, 2'b01}) begin
      fails++; $display("FAIL beq_not_taken: got %b expected %b", {state_o, pc_we, npc_sel}, 6'b010001);
    end
  endtask

  task automatic test_jump();
    do_reset();
    fetch(0, 32'h008000EF);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, ext_op} !== {3'd1, 3'b100}) begin
      fails++; $display("FAIL jal_decode: got %b expected %b", {state_o, ext_op}, 6'b001100);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, pc_we, reg_we, alu_src_a, alu_src_b} !== {3'd2, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL jal_exec: got %b expected %b", {state_o, pc_we, reg_we, alu_src_a, alu_src_b}, 7'b0100011);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, reg_we, wd_sel, pc_we, npc_sel} !== {3'd4, 1'b1, 2'b10, 1'b1, 2'b01}) begin
      fails++; $display("FAIL jal_wb: got %b expected %b", {state_o, reg_we, wd_sel, pc_we, npc_sel}, 9'b100110101);
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    fetch(0, 32'h000080E7);
    next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, reg_we, wd_sel, pc_we, npc_sel} !== {3'd4, 1'b1, 2'b10, 1'b1, 2'b10}) begin
      fails++; $display("FAIL jalr_wb: got %b expected %b", {state_o, reg_we, wd_sel, pc_we, npc_sel}, 9'b100110110);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    fetch(0, 32'h0000007F);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, illegal} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL ill_decode: got %b expected %b", {state_o, illegal}, 4'b0010);
    end
    for (int i = 0; i < 3; i++) begin
      next_cyc(1'b1, 1'b1, 1'b1);
      asserts++;
      if ({state_o, illegal, imem_req, ir_we, reg_we, dmem_req, pc_we} !== {3'd5, 1'b1, 5'b00000}) begin
        fails++; $display("FAIL ill_trap%0d: got %b expected %b", i, {state_o, illegal, imem_req, ir_we, reg_we, dmem_req, pc_we}, 9'b101100000);
      end
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    asserts++;
    if ({state_o, illegal} !== 4'b0000) begin
      fails++; $display("FAIL ill_cleared: got %b expected %b", {state_o, illegal}, 4'b0000);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_cyc(1'b0, 1'b0, 1'b0);
      asserts++;
      if ({state_o, imem_req, bus_err} !== {3'd0, 1'b1, 1'b0}) begin
        fails++; $display("FAIL to_wait%0d: got %b expected %b", i, {state_o, imem_req, bus_err}, 5'b00010);
      end
    end
    for (int i = 0; i < 2; i++) begin
      next_cyc(1'b1, 1'b0, 1'b0);
      asserts++;
      if ({state_o, bus_err, imem_req, ir_we} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
        fails++; $display("FAIL to_trap%0d: got %b expected %b", i, {state_o, bus_err, imem_req, ir_we}, 6'b101100);
      end
    end
    do_reset();
    fetch(3, 32'h00500093);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, bus_err} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL to_ack_limit: got %b expected %b", {state_o, bus_err}, 4'b0010);
    end
    do_reset();
    fetch(0, 32'h0000A103);
    next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b1, 1'b0);
    asserts++;
    if ({state_o, bus_err, dmem_req, reg_we} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL to_dmem: got %b expected %b", {state_o, bus_err, dmem_req, reg_we}, 6'b101100);
    end
    do_reset();
    fetch(0, 32'h0000A103);
    next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    asserts++;
    if ({state_o, dmem_req} !== {3'd3, 1'b1}) begin
      fails++; $display("FAIL abort_pre: got %b expected %b", {state_o, dmem_req}, 4'b0111);
    end
    #2;
    rstn = 1'b0;
    #1;
    asserts++;
    if ({state_o, dmem_req, reg_we, imem_req} !== 6'b000000) begin
      fails++; $display("FAIL abort_mem: got %b expected %b", {state_o, dmem_req, reg_we, imem_req}, 6'b000000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_load_store();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
